// File: rtl/jt51_exp_addr_if.sv
// Operator sample bus into the exponent-address stage and the aligned sideband out of it.
// AM inputs exist only when JT51_EXP_AM_EN is defined.
interface jt51_exp_addr_if;
  logic        in_valid;
  logic [11:0] logsin;
  logic        sign;
  logic [9:0]  eg_att;
`ifdef JT51_EXP_AM_EN
  logic [7:0]  am;
  logic        am_en;
`endif
  logic [4:0]  rom_addr;
  logic        out_valid;
  logic [2:0]  sub_idx;
  logic [4:0]  shift;
  logic        sign_out;
  logic        mute;

  modport master (
    output in_valid, logsin, sign, eg_att,
`ifdef JT51_EXP_AM_EN
    output am, am_en,
`endif
    input  rom_addr, out_valid, sub_idx, shift, sign_out, mute
  );

  modport slave (
    input  in_valid, logsin, sign, eg_att,
`ifdef JT51_EXP_AM_EN
    input  am, am_en,
`endif
    output rom_addr, out_valid, sub_idx, shift, sign_out, mute
  );
endinterface

// File: rtl/jt51_exp_addr.sv
// Sums log-sine, envelope and optional AM attenuation, addresses the exponent ROM and
// delays the sideband to meet its registered word. AM term enabled by JT51_EXP_AM_EN.
module jt51_exp_addr #(
  parameter int AM_SHIFT = 3,
  parameter int MUTE_SH  = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  jt51_exp_addr_if.slave bus
);

  localparam logic [4:0] MUTE_LIM = 5'(MUTE_SH);

`ifdef JT51_EXP_AM_EN
  // Returns {sat, att}: full scale once the 14-bit sum exceeds 13 bits.
  function automatic logic [13:0] sat_att(input logic [13:0] sum);
    if (sum > 14'd8191) return {1'b1, 13'h1FFF};
    else                return {1'b0, sum[12:0]};
  endfunction
`endif

  function automatic logic mute_of(input logic sat, input logic [4:0] sh);
    return sat | (sh >= MUTE_LIM);
  endfunction

  logic [12:0] att_c;
  logic        sat_c;

  always_comb begin
    att_c = '0;
    sat_c = 1'b0;
`ifdef JT51_EXP_AM_EN
    begin
      logic [13:0] am_term;
      logic [13:0] sum_c;
      am_term = bus.am_en ? (14'(bus.am) << AM_SHIFT) : 14'd0;
      sum_c   = 14'(bus.logsin) + 14'({bus.eg_att, 2'b00}) + am_term;
      {sat_c, att_c} = sat_att(sum_c);
    end
`else
    // Without AM the sum peaks at 8187 and cannot overflow 13 bits.
    att_c = 13'(bus.logsin) + 13'({bus.eg_att, 2'b00});
    sat_c = 1'b0;
`endif
  end

  logic        vld_p0;
  logic [12:0] att_p0;
  logic        sat_p0;
  logic        sign_p0;
  logic [4:0]  rom_addr_p0;

  logic        vld_p1;
  logic [2:0]  sub_idx_p1;
  logic [4:0]  shift_p1;
  logic        sign_p1;
  logic        mute_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0      <= 1'b0;
      att_p0      <= '0;
      sat_p0      <= 1'b0;
      sign_p0     <= 1'b0;
      rom_addr_p0 <= '0;
      vld_p1      <= 1'b0;
      sub_idx_p1  <= '0;
      shift_p1    <= '0;
      sign_p1     <= 1'b0;
      mute_p1     <= 1'b0;
    end else if (cen) begin
      // Stage p0: capture attenuation, present ROM address
      vld_p0 <= bus.in_valid;
      if (bus.in_valid) begin
        att_p0      <= att_c;
        sat_p0      <= sat_c;
        sign_p0     <= bus.sign;
        rom_addr_p0 <= att_c[7:3];
      end
      // Stage p1: sideband aligned with the ROM output word
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        sub_idx_p1 <= att_p0[2:0];
        shift_p1   <= att_p0[12:8];
        sign_p1    <= sign_p0;
        mute_p1    <= mute_of(sat_p0, att_p0[12:8]);
      end
    end
  end

  assign bus.rom_addr  = rom_addr_p0;
  assign bus.out_valid = vld_p1;
  assign bus.sub_idx   = sub_idx_p1;
  assign bus.shift     = shift_p1;
  assign bus.sign_out  = sign_p1;
  assign bus.mute      = mute_p1;

endmodule

// File: tb/tb_jt51_exp_addr.sv
// Directed bench for jt51_exp_addr; AM scenarios run only when JT51_EXP_AM_EN is defined.
module tb_jt51_exp_addr;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cen = 1'b1;
  int   checks = 0;
  int   passes = 0;

  jt51_exp_addr_if bus();

  jt51_exp_addr dut (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] ls, input logic [9:0] eg, input logic sg);
    bus.in_valid = v;
    bus.logsin   = ls;
    bus.eg_att   = eg;
    bus.sign     = sg;
  endtask

  task automatic test_reset();
    drive(1'b1, 12'd171, 10'd16, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    drive(1'b0, 12'd0, 10'd0, 1'b0);
    tick();
    rst = 1'b0;
    checks++; if (bus.rom_addr !== 5'd0) $display("FAIL reset_rom_addr: got %0d want 0", bus.rom_addr); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0d want 0", bus.out_valid); else passes++;
    checks++; if (bus.sub_idx !== 3'd0) $display("FAIL reset_sub_idx: got %0d want 0", bus.sub_idx); else passes++;
    checks++; if (bus.shift !== 5'd0) $display("FAIL reset_shift: got %0d want 0", bus.shift); else passes++;
    checks++; if (bus.sign_out !== 1'b0) $display("FAIL reset_sign_out: got %0d want 0", bus.sign_out); else passes++;
    checks++; if (bus.mute !== 1'b0) $display("FAIL reset_mute: got %0d want 0", bus.mute); else passes++;
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL idle_out_valid: got %0d want 0", bus.out_valid); else passes++;
  endtask

  task automatic test_vectors();
    logic [11:0] ls   [5] = '{12'd171, 12'd0, 12'd0,  12'd0,  12'd4095};
    logic [9:0]  eg   [5] = '{10'd16,  10'd0, 10'd768, 10'd832, 10'd1023};
    logic        sg   [5] = '{1'b0,    1'b1, 1'b0,   1'b1,   1'b0};
    logic [4:0]  addr [5] = '{5'd29,   5'd0, 5'd0,   5'd0,   5'd31};
    logic [2:0]  sub  [5] = '{3'd3,    3'd0, 3'd0,   3'd0,   3'd3};
    logic [4:0]  sh   [5] = '{5'd0,    5'd0, 5'd12,  5'd13,  5'd31};
    logic        mu   [5] = '{1'b0,    1'b0, 1'b0,   1'b1,   1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ls[i], eg[i], sg[i]);
      tick();
      checks++; if (bus.rom_addr !== addr[i]) $display("FAIL vec%0d_rom_addr: got %0d want %0d", i, bus.rom_addr, addr[i]); else passes++;
      drive(1'b0, 12'd5, 10'd100, ~sg[i]);
      tick();
      checks++; if (bus.rom_addr !== addr[i]) $display("FAIL vec%0d_addr_hold: got %0d want %0d", i, bus.rom_addr, addr[i]); else passes++;
      checks++; if (bus.out_valid !== 1'b1) $display("FAIL vec%0d_out_valid: got %0d want 1", i, bus.out_valid); else passes++;
      checks++; if (bus.sub_idx !== sub[i]) $display("FAIL vec%0d_sub_idx: got %0d want %0d", i, bus.sub_idx, sub[i]); else passes++;
      checks++; if (bus.shift !== sh[i]) $display("FAIL vec%0d_shift: got %0d want %0d", i, bus.shift, sh[i]); else passes++;
      checks++; if (bus.sign_out !== sg[i]) $display("FAIL vec%0d_sign_out: got %0d want %0d", i, bus.sign_out, sg[i]); else passes++;
      checks++; if (bus.mute !== mu[i]) $display("FAIL vec%0d_mute: got %0d want %0d", i, bus.mute, mu[i]); else passes++;
      tick();
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL vec%0d_bubble: got %0d want 0", i, bus.out_valid); else passes++;
      checks++; if (bus.shift !== sh[i]) $display("FAIL vec%0d_shift_hold: got %0d want %0d", i, bus.shift, sh[i]); else passes++;
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 12'd171, 10'd16, 1'b0);
    tick();
    checks++; if (bus.rom_addr !== 5'd29) $display("FAIL b2b_addr_a: got %0d want 29", bus.rom_addr); else passes++;
    drive(1'b1, 12'd0, 10'd832, 1'b1);
    tick();
    checks++; if (bus.rom_addr !== 5'd0) $display("FAIL b2b_addr_b: got %0d want 0", bus.rom_addr); else passes++;
    checks++; if ({bus.out_valid, bus.sub_idx, bus.shift, bus.sign_out, bus.mute} !== {1'b1, 3'd3, 5'd0, 1'b0, 1'b0})
      $display("FAIL b2b_side_a: got %b want %b", {bus.out_valid, bus.sub_idx, bus.shift, bus.sign_out, bus.mute}, {1'b1, 3'd3, 5'd0, 1'b0, 1'b0}); else passes++;
    drive(1'b0, 12'd0, 10'd0, 1'b0);
    tick();
    checks++; if ({bus.out_valid, bus.sub_idx, bus.shift, bus.sign_out, bus.mute} !== {1'b1, 3'd0, 5'd13, 1'b1, 1'b1})
      $display("FAIL b2b_side_b: got %b want %b", {bus.out_valid, bus.sub_idx, bus.shift, bus.sign_out, bus.mute}, {1'b1, 3'd0, 5'd13, 1'b1, 1'b1}); else passes++;
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain: got %0d want 0", bus.out_valid); else passes++;
  endtask

  task automatic test_cen();
    drive(1'b1, 12'd171, 10'd16, 1'b1);
    cen = 1'b1;
    tick();
    checks++; if (bus.rom_addr !== 5'd29) $display("FAIL cen_addr_x: got %0d want 29", bus.rom_addr); else passes++;
    drive(1'b1, 12'd0, 10'd768, 1'b0);
    cen = 1'b0;
    tick();
    tick();
    checks++; if (bus.rom_addr !== 5'd29) $display("FAIL cen_frozen_addr: got %0d want 29", bus.rom_addr); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL cen_frozen_valid: got %0d want 0", bus.out_valid); else passes++;
    cen = 1'b1;
    tick();
    checks++; if (bus.rom_addr !== 5'd0) $display("FAIL cen_addr_y: got %0d want 0", bus.rom_addr); else passes++;
    checks++; if ({bus.out_valid, bus.sub_idx, bus.shift, bus.sign_out} !== {1'b1, 3'd3, 5'd0, 1'b1})
      $display("FAIL cen_side_x: got %b want %b", {bus.out_valid, bus.sub_idx, bus.shift, bus.sign_out}, {1'b1, 3'd3, 5'd0, 1'b1}); else passes++;
    drive(1'b0, 12'd0, 10'd0, 1'b0);
    tick();
    checks++; if ({bus.out_valid, bus.shift, bus.sign_out, bus.mute} !== {1'b1, 5'd12, 1'b0, 1'b0})
      $display("FAIL cen_side_y: got %b want %b", {bus.out_valid, bus.shift, bus.sign_out, bus.mute}, {1'b1, 5'd12, 1'b0, 1'b0}); else passes++;
    cen = 1'b0;
    tick();
    checks++; if ({bus.out_valid, bus.shift} !== {1'b1, 5'd12}) $display("FAIL cen_hold_y: got %b want %b", {bus.out_valid, bus.shift}, {1'b1, 5'd12}); else passes++;
    cen = 1'b1;
    tick();
  endtask

  task automatic test_rst_mid();
    drive(1'b1, 12'd0, 10'd832, 1'b1);
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_pre_valid: got %0d want 0", bus.out_valid); else passes++;
    drive(1'b0, 12'd0, 10'd0, 1'b0);
    rst = 1'b1;
    cen = 1'b0;
    tick();
    rst = 1'b0;
    cen = 1'b1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %0d want 0", bus.out_valid); else passes++;
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_stale_valid: got %0d want 0", bus.out_valid); else passes++;
    checks++; if ({bus.shift, bus.mute, bus.sign_out} !== {5'd0, 1'b0, 1'b0})
      $display("FAIL mid_stale_side: got %b want %b", {bus.shift, bus.mute, bus.sign_out}, {5'd0, 1'b0, 1'b0}); else passes++;
  endtask

`ifdef JT51_EXP_AM_EN
  task automatic test_am();
    drive(1'b1, 12'd4095, 10'd1023, 1'b0);
    bus.am = 8'd255;
    bus.am_en = 1'b1;
    tick();
    checks++; if (bus.rom_addr !== 5'd31) $display("FAIL am_sat_addr: got %0d want 31", bus.rom_addr); else passes++;
    drive(1'b0, 12'd0, 10'd0, 1'b0);
    tick();
    checks++; if ({bus.out_valid, bus.sub_idx, bus.shift, bus.mute} !== {1'b1, 3'd7, 5'd31, 1'b1})
      $display("FAIL am_sat_side: got %b want %b", {bus.out_valid, bus.sub_idx, bus.shift, bus.mute}, {1'b1, 3'd7, 5'd31, 1'b1}); else passes++;
    drive(1'b1, 12'd4095, 10'd1023, 1'b0);
    bus.am_en = 1'b0;
    tick();
    checks++; if (bus.rom_addr !== 5'd31) $display("FAIL am_off_addr: got %0d want 31", bus.rom_addr); else passes++;
    drive(1'b0, 12'd0, 10'd0, 1'b0);
    tick();
    checks++; if ({bus.out_valid, bus.sub_idx, bus.shift, bus.mute} !== {1'b1, 3'd3, 5'd31, 1'b1})
      $display("FAIL am_off_side: got %b want %b", {bus.out_valid, bus.sub_idx, bus.shift, bus.mute}, {1'b1, 3'd3, 5'd31, 1'b1}); else passes++;
    // 40 + 0 + (1<<3)=48: AM shifted by three lands in sub-index/address bits
    drive(1'b1, 12'd40, 10'd0, 1'b0);
    bus.am = 8'd1;
    bus.am_en = 1'b1;
    tick();
    checks++; if (bus.rom_addr !== 5'd6) $display("FAIL am_small_addr: got %0d want 6", bus.rom_addr); else passes++;
    drive(1'b0, 12'd0, 10'd0, 1'b0);
    bus.am_en = 1'b0;
    tick();
  endtask
`endif

  initial begin
    drive(1'b0, 12'd0, 10'd0, 1'b0);
`ifdef JT51_EXP_AM_EN
    bus.am    = 8'd0;
    bus.am_en = 1'b0;
`endif
    test_reset();
    test_vectors();
    test_back_to_back();
    test_cen();
    test_rst_mid();
`ifdef JT51_EXP_AM_EN
    test_am();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
